// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU pass-through, single-cycle stores, two-edge loads.
// Latency: ALU/store result 1 edge after acceptance, load result 2 edges after acceptance.
// Backpressure: stall is high during the single LOAD cycle; upstream holds its inputs.
module mem_access_stage #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [15:0] ans_ex,
  input  logic [15:0] st_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic [15:0] ans_dm,
  output logic        ans_dm_valid,
  output logic        stall,
  output logic        err
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] addr;
  logic [AW-1:0] ld_addr;
  logic          accept;
  logic          is_store;
  logic          is_load;
  logic          mem_we;
  logic          unused_addr_hi;

  // Upper address bits alias onto the same words and are deliberately dropped.
  assign addr           = ans_ex[AW-1:0];
  assign unused_addr_hi = ^ans_ex[15:AW];

  // Ops are only taken in IDLE; a combined rd+wr is treated as a store.
  assign accept   = (state == IDLE) && valid_in;
  assign is_store = accept && mem_wr;
  assign is_load  = accept && mem_rd && !mem_wr;
  assign mem_we   = is_store && !reset;

  assign stall = (state == LOAD);

  // Next-state decode: a load spends exactly one cycle in LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_load) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any load in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered result, valid and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ans_dm       <= 16'h0000;
      ans_dm_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      err          <= is_store && mem_rd;
      ans_dm_valid <= 1'b0;
      if (state == LOAD) begin
        ans_dm       <= mem[ld_addr];
        ans_dm_valid <= 1'b1;
      end else if (accept && !is_load) begin
        ans_dm       <= ans_ex;
        ans_dm_valid <= 1'b1;
      end
    end
  end

  // Capture the load address so LOAD ignores whatever upstream presents.
  always_ff @(posedge clk) begin
    if (is_load) ld_addr <= addr;
  end

  // Data memory write port; contents survive reset. Read happens in LOAD,
  // one edge after any preceding store, so store-then-load sees new data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= st_data;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios then random ops
// against an array-based reference of memory contents and expected results.
module tb_mem_access_stage;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [15:0] ans_ex;
  logic [15:0] st_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] ans_dm;
  logic        ans_dm_valid;
  logic        stall;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdl [0:255];
  logic [15:0] exp_dm;

  always #5 clk = ~clk;

  mem_access_stage #(.AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ans_ex       (ans_ex),
    .st_data      (st_data),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .ans_dm       (ans_dm),
    .ans_dm_valid (ans_dm_valid),
    .stall        (stall),
    .err          (err)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input logic [15:0] a);
    @(negedge clk);
    valid_in = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
    ans_ex = a; st_data = 16'($urandom);
    after_edge();
    exp_dm = a;
    chk16("alu_dm", ans_dm, exp_dm);
    chk1("alu_vld", ans_dm_valid, 1'b1);
    chk1("alu_stall", stall, 1'b0);
    chk1("alu_err", err, 1'b0);
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic both);
    @(negedge clk);
    valid_in = 1'b1; mem_rd = both; mem_wr = 1'b1;
    ans_ex = a; st_data = d;
    after_edge();
    mdl[a[7:0]] = d;
    exp_dm = a;
    chk16("st_dm", ans_dm, exp_dm);
    chk1("st_vld", ans_dm_valid, 1'b1);
    chk1("st_stall", stall, 1'b0);
    chk1("st_err", err, both);
  endtask

  task automatic do_load(input logic [15:0] a);
    @(negedge clk);
    valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
    ans_ex = a; st_data = 16'($urandom);
    after_edge();
    chk1("ld_stall", stall, 1'b1);
    chk1("ld_vld0", ans_dm_valid, 1'b0);
    chk1("ld_err", err, 1'b0);
    chk16("ld_hold", ans_dm, exp_dm);
    // Garbage during LOAD, including a write request, must be ignored.
    @(negedge clk);
    valid_in = 1'b1; mem_rd = 1'($urandom); mem_wr = 1'b1;
    ans_ex = 16'($urandom); st_data = 16'($urandom);
    after_edge();
    exp_dm = mdl[a[7:0]];
    chk16("ld_dm", ans_dm, exp_dm);
    chk1("ld_vld1", ans_dm_valid, 1'b1);
    chk1("ld_stall_end", stall, 1'b0);
    chk1("ld_err_end", err, 1'b0);
  endtask

  task automatic do_idle();
    @(negedge clk);
    valid_in = 1'b0; mem_rd = 1'($urandom); mem_wr = 1'($urandom);
    ans_ex = 16'($urandom); st_data = 16'($urandom);
    after_edge();
    chk16("idle_dm", ans_dm, exp_dm);
    chk1("idle_vld", ans_dm_valid, 1'b0);
    chk1("idle_stall", stall, 1'b0);
    chk1("idle_err", err, 1'b0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    ans_ex = 16'h0; st_data = 16'h0;
    exp_dm = 16'h0;
    repeat (2) after_edge();
    chk16("rst_dm", ans_dm, 16'h0000);
    chk1("rst_vld", ans_dm_valid, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Fill every word, with random upper address bits to exercise aliasing.
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {8'($urandom), 8'(i)};
      do_store(a, 16'($urandom), 1'b0);
    end
    do_store(16'h0005, 16'h1111, 1'b0);

    // Reset with a store presented: no write, outputs cleared, memory kept.
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0;
    ans_ex = 16'h0005; st_data = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      after_edge();
      chk16("rsts_dm", ans_dm, 16'h0000);
      chk1("rsts_vld", ans_dm_valid, 1'b0);
      chk1("rsts_stall", stall, 1'b0);
      if (i == 0) @(negedge clk);
    end
    exp_dm = 16'h0000;
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0; mem_wr = 1'b0;
    do_load(16'h0005);
    chk16("rst_keep_mem", ans_dm, 16'h1111);

    do_alu(16'h1234);
    do_store(16'h0003, 16'hA5A5, 1'b0);
    do_load(16'h0003);
    chk16("st_ld_a5a5", ans_dm, 16'hA5A5);

    do_store(16'h0107, 16'h00FF, 1'b0);
    do_load(16'h0007);
    chk16("alias_ff", ans_dm, 16'h00FF);

    do_store(16'h0010, 16'h7777, 1'b1);
    do_idle();
    do_load(16'h0010);
    chk16("illegal_ld", ans_dm, 16'h7777);

    // Back-to-back loads.
    do_load(16'h0003);
    do_load(16'h0007);

    // Reset during LOAD aborts the load.
    @(negedge clk);
    valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; ans_ex = 16'h0021;
    after_edge();
    chk1("rml_stall", stall, 1'b1);
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0; mem_rd = 1'b0;
    after_edge();
    exp_dm = 16'h0000;
    chk1("rml_vld", ans_dm_valid, 1'b0);
    chk1("rml_stall0", stall, 1'b0);
    chk16("rml_dm", ans_dm, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    after_edge();
    chk1("rml_vld_after", ans_dm_valid, 1'b0);
    chk1("rml_stall_after", stall, 1'b0);

    // Random mix of ops.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = 16'($urandom);
      case ($urandom_range(0, 4))
        0: do_alu(a);
        1: do_store(a, 16'($urandom), 1'b0);
        2: do_store(a, 16'($urandom), 1'b1);
        3: do_load(a);
        default: do_idle();
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: AW, default 8, data-memory word-address width (2**AW words of 16 bits).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: valid_in  input  1  execute-stage result present this cycle.
REQ-005 Port: ans_ex  input  16  ALU result; memory word address for loads/stores.
REQ-006 Port: st_data  input  16  store data.
REQ-007 Port: mem_rd  input  1  load request, qualified by valid_in.
REQ-008 Port: mem_wr  input  1  store request, qualified by valid_in.
REQ-009 Port: ans_dm  output  16  stage result for the writeback register; registered.
REQ-010 Port: ans_dm_valid  output  1  ans_dm updated by an accepted op on the last edge; registered.
REQ-011 Port: stall  output  1  upstream must hold all inputs stable while high.
REQ-012 Port: err  output  1  one-cycle pulse on an illegal op; registered.

Function
REQ-013 The block SHALL implement a 2**AW x 16 data memory addressed by ans_ex[AW-1:0], with ans_ex[15:AW] ignored.
REQ-014 The block SHALL implement a two-state FSM, IDLE and LOAD, where stall = (state == LOAD).
REQ-015 In IDLE with valid_in=0 at an edge, the block SHALL clear ans_dm_valid, hold ans_dm and perform no memory write.
REQ-016 In IDLE with valid_in=1, mem_rd=0 and mem_wr=0 (ALU op), the block SHALL register ans_dm<=ans_ex and ans_dm_valid<=1, giving 1-cycle latency.
REQ-017 In IDLE with valid_in=1 and mem_wr=1, the block SHALL write st_data into mem[ans_ex[AW-1:0]] and register ans_dm<=ans_ex and ans_dm_valid<=1.
REQ-018 In IDLE with valid_in=1, mem_rd=1 and mem_wr=0, the block SHALL latch the address, enter LOAD and clear ans_dm_valid.
REQ-019 In LOAD, the block SHALL register ans_dm<=mem[latched address] and ans_dm_valid<=1, and return to IDLE; load latency is 2 edges from acceptance, with stall high for exactly 1 cycle.
REQ-020 In LOAD, the block SHALL ignore valid_in, mem_rd, mem_wr, ans_ex and st_data, and perform no write.
REQ-021 With mem_rd=1 and mem_wr=1 together in IDLE (with valid_in=1), the block SHALL execute the op as a store per REQ-017, skip the load, and pulse err=1 for one cycle; otherwise err=0.
REQ-022 A store accepted at edge N followed by a load of the same address accepted at edge N+1 SHALL return the newly stored data (no read-before-write hazard).
REQ-023 The block SHALL accept a new op in the IDLE cycle that immediately follows LOAD, so back-to-back loads complete every 2 cycles.
REQ-024 All outputs SHALL be glitch-free registered values, except stall, which is decoded only from the state register.

Reset
REQ-025 On any edge with reset=1, the block SHALL set state=IDLE, ans_dm=16'h0000, ans_dm_valid=0 and err=0.
REQ-026 During reset, the block SHALL suppress all memory writes regardless of the other inputs.
REQ-027 Memory contents SHALL NOT be cleared by reset and SHALL retain their values across it.
REQ-028 Reset asserted while in LOAD SHALL abort the load, so that no ans_dm_valid pulse results from it.
REQ-029 Reset SHALL take priority over every other condition.

Verification
REQ-030 Scenario, reset: reset=1 for 2 cycles with valid_in=1, mem_wr=1, ans_ex=16'h0005, st_data=16'hBEEF -> ans_dm=0, ans_dm_valid=0, stall=0; a later load of address 5 must not return BEEF.
REQ-031 Scenario, ALU pass-through: valid_in=1, ans_ex=16'h1234, no rd/wr -> next edge ans_dm=16'h1234, ans_dm_valid=1, stall=0 throughout.
REQ-032 Scenario, store then load: store st_data=16'hA5A5 at ans_ex=16'h0003, then load ans_ex=16'h0003 on the next cycle -> stall high 1 cycle, then ans_dm=16'hA5A5 with ans_dm_valid=1 two edges after load acceptance.
REQ-033 Scenario, aliasing: store 16'h00FF at ans_ex=16'h0107 with AW=8, then load ans_ex=16'h0007 -> ans_dm=16'h00FF.
REQ-034 Scenario, illegal op: mem_rd=1 and mem_wr=1, ans_ex=16'h0010, st_data=16'h7777 -> err pulses for 1 cycle, no stall, ans_dm=16'h0010; a later load of address 16'h0010 returns 16'h7777.
REQ-035 Scenario, reset mid-load: accept a load, then assert reset during the LOAD cycle -> no ans_dm_valid pulse, state IDLE, stall=0 the cycle after.
